// File: rtl/gbf_db_ctrl.sv
// ---------------------------------------------------------------------------
// gbf_db_ctrl -- double-buffer (ping-pong) controller for a two-bank global
// buffer. A producer fills one bank a tile at a time while a consumer drains
// the other; the banks swap roles each time a tile is closed (fill side) or
// fully read (drain side).
//
// Parameters
//   DATA_BITWIDTH  width of one buffer word
//   ADDR_BITWIDTH  bank address width
//   DEPTH          words per bank (DEPTH <= 2**ADDR_BITWIDTH)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   clr                      synchronous soft clear (same effect as rst)
//   fill_valid/data/last     producer word, last word of tile
//   fill_ready               word accepted when high together with fill_valid
//   drain_en                 consumer requests one read this cycle
//   drain_valid/data/last    read word, one cycle after the read issue
//   en1a/we1a/addr1a/w_data1a, en2a/we2a/addr2a/w_data2a
//                            write ports (a) of bank1 / bank2
//   en1b/addr1b/r_data1b, en2b/addr2b/r_data2b
//                            read ports (b) of bank1 / bank2 (registered read)
//   bank_full                bit0 = bank1 full, bit1 = bank2 full
//   busy                     any bank full or a read word in flight
// ---------------------------------------------------------------------------
module gbf_db_ctrl #(
    parameter int DATA_BITWIDTH = 512,
    parameter int ADDR_BITWIDTH = 5,
    parameter int DEPTH         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    // fill side
    input  logic                     fill_valid,
    input  logic [DATA_BITWIDTH-1:0] fill_data,
    input  logic                     fill_last,
    output logic                     fill_ready,
    // drain side
    input  logic                     drain_en,
    output logic                     drain_valid,
    output logic [DATA_BITWIDTH-1:0] drain_data,
    output logic                     drain_last,
    // RAM write ports
    output logic                     en1a,
    output logic                     we1a,
    output logic [ADDR_BITWIDTH-1:0] addr1a,
    output logic [DATA_BITWIDTH-1:0] w_data1a,
    output logic                     en2a,
    output logic                     we2a,
    output logic [ADDR_BITWIDTH-1:0] addr2a,
    output logic [DATA_BITWIDTH-1:0] w_data2a,
    // RAM read ports
    output logic                     en1b,
    output logic [ADDR_BITWIDTH-1:0] addr1b,
    input  logic [DATA_BITWIDTH-1:0] r_data1b,
    output logic                     en2b,
    output logic [ADDR_BITWIDTH-1:0] addr2b,
    input  logic [DATA_BITWIDTH-1:0] r_data2b,
    // status
    output logic [1:0]               bank_full,
    output logic                     busy
);

    // Word counts need one extra bit so a completely full bank (DEPTH words)
    // can be represented when DEPTH == 2**ADDR_BITWIDTH.
    localparam int LW = ADDR_BITWIDTH + 1;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

    // Bank select encoding: 0 = bank1, 1 = bank2.
    logic                     wr_sel_reg,  wr_sel_next;
    logic                     rd_sel_reg,  rd_sel_next;
    logic [ADDR_BITWIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_BITWIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic [1:0]               full_reg,    full_next;
    logic [LW-1:0]            len_reg  [2];
    logic [LW-1:0]            len_next [2];

    // Read pipeline: tracks the word coming back from the registered RAM read.
    logic                     dv_reg,    dv_next;
    logic                     dlast_reg, dlast_next;
    logic                     dbank_reg, dbank_next;

    logic                     fill_beat;
    logic                     fill_close;
    logic                     rd_issue;
    logic                     rd_close;
    logic [LW-1:0]            cur_len;

    // Per-bank port views, mapped onto the flat RAM ports below.
    logic [1:0]               a_en;
    logic [ADDR_BITWIDTH-1:0] a_addr [2];
    logic [DATA_BITWIDTH-1:0] a_data [2];
    logic [1:0]               b_en;
    logic [ADDR_BITWIDTH-1:0] b_addr [2];

    // ------------------------------------------------------------------
    // Handshake and tile-boundary decode
    // ------------------------------------------------------------------
    assign fill_ready = !full_reg[wr_sel_reg];
    assign fill_beat  = fill_valid && fill_ready;
    // A tile closes on the producer's last flag or when the bank runs out.
    assign fill_close = fill_beat && (fill_last || (wr_addr_reg == LAST_ADDR));

    // Fill only targets a non-full bank and drain only a full one, so the
    // two sides can never touch the same bank in the same cycle.
    assign rd_issue = drain_en && full_reg[rd_sel_reg];
    assign cur_len  = len_reg[rd_sel_reg];
    assign rd_close = rd_issue && (LW'(rd_addr_reg) == (cur_len - LW'(1)));

    // ------------------------------------------------------------------
    // Per-bank RAM port generation
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign a_en[gi]   = fill_beat && (wr_sel_reg == 1'(gi));
            assign a_addr[gi] = a_en[gi] ? wr_addr_reg : '0;
            assign a_data[gi] = a_en[gi] ? fill_data   : '0;
            assign b_en[gi]   = rd_issue  && (rd_sel_reg == 1'(gi));
            assign b_addr[gi] = b_en[gi] ? rd_addr_reg : '0;
        end
    endgenerate

    assign en1a     = a_en[0];
    assign we1a     = a_en[0];
    assign addr1a   = a_addr[0];
    assign w_data1a = a_data[0];
    assign en2a     = a_en[1];
    assign we2a     = a_en[1];
    assign addr2a   = a_addr[1];
    assign w_data2a = a_data[1];

    assign en1b     = b_en[0];
    assign addr1b   = b_addr[0];
    assign en2b     = b_en[1];
    assign addr2b   = b_addr[1];

    // ------------------------------------------------------------------
    // Drain output: the RAM presents data one cycle after the issue, so the
    // bank recorded at issue time selects which read port to forward.
    // ------------------------------------------------------------------
    assign drain_valid = dv_reg;
    assign drain_last  = dlast_reg;
    assign drain_data  = dv_reg ? (dbank_reg ? r_data2b : r_data1b) : '0;

    assign bank_full = full_reg;
    assign busy      = (|full_reg) || dv_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_sel_next  = wr_sel_reg;
        rd_sel_next  = rd_sel_reg;
        wr_addr_next = wr_addr_reg;
        rd_addr_next = rd_addr_reg;
        full_next    = full_reg;
        len_next[0]  = len_reg[0];
        len_next[1]  = len_reg[1];
        dv_next      = rd_issue;
        dlast_next   = rd_close;
        dbank_next   = rd_sel_reg;

        if (fill_beat) begin
            if (fill_close) begin
                full_next[wr_sel_reg] = 1'b1;
                len_next[wr_sel_reg]  = LW'(wr_addr_reg) + LW'(1);
                wr_sel_next           = !wr_sel_reg;
                wr_addr_next          = '0;
            end else begin
                wr_addr_next = wr_addr_reg + ADDR_BITWIDTH'(1);
            end
        end

        // Applied after the fill update: the banks differ, so a set on one
        // and a clear on the other in the same cycle both survive.
        if (rd_issue) begin
            if (rd_close) begin
                full_next[rd_sel_reg] = 1'b0;
                rd_sel_next           = !rd_sel_reg;
                rd_addr_next          = '0;
            end else begin
                rd_addr_next = rd_addr_reg + ADDR_BITWIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers. clr has the same effect as rst but is synchronous
    // and overrides any fill/drain activity in its cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel_reg  <= 1'b0;
            rd_sel_reg  <= 1'b0;
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
            full_reg    <= '0;
            len_reg[0]  <= '0;
            len_reg[1]  <= '0;
            dv_reg      <= 1'b0;
            dlast_reg   <= 1'b0;
            dbank_reg   <= 1'b0;
        end else if (clr) begin
            wr_sel_reg  <= 1'b0;
            rd_sel_reg  <= 1'b0;
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
            full_reg    <= '0;
            len_reg[0]  <= '0;
            len_reg[1]  <= '0;
            dv_reg      <= 1'b0;
            dlast_reg   <= 1'b0;
            dbank_reg   <= 1'b0;
        end else begin
            wr_sel_reg  <= wr_sel_next;
            rd_sel_reg  <= rd_sel_next;
            wr_addr_reg <= wr_addr_next;
            rd_addr_reg <= rd_addr_next;
            full_reg    <= full_next;
            len_reg[0]  <= len_next[0];
            len_reg[1]  <= len_next[1];
            dv_reg      <= dv_next;
            dlast_reg   <= dlast_next;
            dbank_reg   <= dbank_next;
        end
    end

endmodule

// File: tb/tb_gbf_db_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gbf_db_ctrl -- self-checking bench for gbf_db_ctrl with two behavioural
// RAM banks (registered read). A cycle-by-cycle vector table covers the basic
// tile fill/drain and ping-pong hand-over; directed sequences cover bank
// auto-close, both-banks-full back-pressure, streaming, reset and clear.
// ---------------------------------------------------------------------------
module tb_gbf_db_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int DP = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          fill_valid = 1'b0;
    logic [DW-1:0] fill_data  = '0;
    logic          fill_last  = 1'b0;
    logic          fill_ready;
    logic          drain_en   = 1'b0;
    logic          drain_valid;
    logic [DW-1:0] drain_data;
    logic          drain_last;
    logic          en1a, we1a, en2a, we2a, en1b, en2b;
    logic [AW-1:0] addr1a, addr2a, addr1b, addr2b;
    logic [DW-1:0] w_data1a, w_data2a, r_data1b, r_data2b;
    logic [1:0]    bank_full;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gbf_db_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_last(fill_last),
        .fill_ready(fill_ready),
        .drain_en(drain_en), .drain_valid(drain_valid), .drain_data(drain_data),
        .drain_last(drain_last),
        .en1a(en1a), .we1a(we1a), .addr1a(addr1a), .w_data1a(w_data1a),
        .en2a(en2a), .we2a(we2a), .addr2a(addr2a), .w_data2a(w_data2a),
        .en1b(en1b), .addr1b(addr1b), .r_data1b(r_data1b),
        .en2b(en2b), .addr2b(addr2b), .r_data2b(r_data2b),
        .bank_full(bank_full), .busy(busy)
    );

    // Behavioural banks with a one-cycle registered read.
    logic [DW-1:0] mem1 [DP];
    logic [DW-1:0] mem2 [DP];
    always @(posedge clk) begin
        if (en1a && we1a) mem1[addr1a] <= w_data1a;
        if (en2a && we2a) mem2[addr2a] <= w_data2a;
        if (en1b) r_data1b <= mem1[addr1b];
        if (en2b) r_data2b <= mem2[addr2b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic fv, input logic [DW-1:0] fd, input logic fl, input logic de);
        @(negedge clk);
        fill_valid = fv;
        fill_data  = fd;
        fill_last  = fl;
        drain_en   = de;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b0;
        fill_valid = 1'b0;
        fill_last  = 1'b0;
        drain_en   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic          fv;
        logic [DW-1:0] fd;
        logic          fl;
        logic          de;
        logic          fr;
        logic [1:0]    aen;    // {bank2, bank1} write enables
        logic [AW-1:0] aaddr;
        logic [1:0]    ben;    // {bank2, bank1} read enables
        logic [AW-1:0] baddr;
        logic          dv;
        logic [DW-1:0] dd;
        logic          dl;
        logic [1:0]    bf;
    } vec_t;

    function automatic vec_t mk(
        input logic fv, input logic [DW-1:0] fd, input logic fl, input logic de,
        input logic fr, input logic [1:0] aen, input logic [AW-1:0] aaddr,
        input logic [1:0] ben, input logic [AW-1:0] baddr,
        input logic dv, input logic [DW-1:0] dd, input logic dl, input logic [1:0] bf);
        vec_t r;
        r.fv = fv; r.fd = fd; r.fl = fl; r.de = de; r.fr = fr;
        r.aen = aen; r.aaddr = aaddr; r.ben = ben; r.baddr = baddr;
        r.dv = dv; r.dd = dd; r.dl = dl; r.bf = bf;
        return r;
    endfunction

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        int lens [4];
        logic [DW-1:0] src_data [64];
        logic          src_last [64];
        int total, sent, rcv, n;

        //             fv  fd        fl  de | fr  aen    aa  ben    ba  dv  dd        dl  bf
        vecs[0]  = mk(0, 16'h0000, 0, 1,   1, 2'b00, 0, 2'b00, 0, 0, 16'h0000, 0, 2'b00);
        vecs[1]  = mk(1, 16'h00A0, 0, 0,   1, 2'b01, 0, 2'b00, 0, 0, 16'h0000, 0, 2'b00);
        vecs[2]  = mk(1, 16'h00A1, 0, 0,   1, 2'b01, 1, 2'b00, 0, 0, 16'h0000, 0, 2'b00);
        vecs[3]  = mk(1, 16'h00A2, 0, 0,   1, 2'b01, 2, 2'b00, 0, 0, 16'h0000, 0, 2'b00);
        vecs[4]  = mk(1, 16'h00A3, 1, 0,   1, 2'b01, 3, 2'b00, 0, 0, 16'h0000, 0, 2'b00);
        vecs[5]  = mk(0, 16'h0000, 0, 1,   1, 2'b00, 0, 2'b01, 0, 0, 16'h0000, 0, 2'b01);
        vecs[6]  = mk(1, 16'h00B0, 0, 1,   1, 2'b10, 0, 2'b01, 1, 1, 16'h00A0, 0, 2'b01);
        vecs[7]  = mk(1, 16'h00B1, 1, 1,   1, 2'b10, 1, 2'b01, 2, 1, 16'h00A1, 0, 2'b01);
        vecs[8]  = mk(1, 16'h00C0, 0, 1,   0, 2'b00, 0, 2'b01, 3, 1, 16'h00A2, 0, 2'b11);
        vecs[9]  = mk(1, 16'h00C0, 0, 1,   1, 2'b01, 0, 2'b10, 0, 1, 16'h00A3, 1, 2'b10);
        vecs[10] = mk(1, 16'h00C1, 1, 1,   1, 2'b01, 1, 2'b10, 1, 1, 16'h00B0, 0, 2'b10);
        vecs[11] = mk(0, 16'h0000, 0, 0,   1, 2'b00, 0, 2'b00, 0, 1, 16'h00B1, 1, 2'b01);
        vecs[12] = mk(0, 16'h0000, 0, 0,   1, 2'b00, 0, 2'b00, 0, 0, 16'h0000, 0, 2'b01);
        vecs[13] = mk(0, 16'h0000, 0, 1,   1, 2'b00, 0, 2'b01, 0, 0, 16'h0000, 0, 2'b01);
        vecs[14] = mk(0, 16'h0000, 0, 1,   1, 2'b00, 0, 2'b01, 1, 1, 16'h00C0, 0, 2'b01);
        vecs[15] = mk(0, 16'h0000, 0, 0,   1, 2'b00, 0, 2'b00, 0, 1, 16'h00C1, 1, 2'b00);
        vecs[16] = mk(0, 16'h0000, 0, 1,   1, 2'b00, 0, 2'b00, 0, 0, 16'h0000, 0, 2'b00);

        // ---------------- reset state ----------------
        drain_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_drain_valid", drain_valid, 0);
        chk("rst_drain_last", drain_last, 0);
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_enables", {en1a, we1a, en2a, we2a, en1b, en2b}, 6'b0);
        drain_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_fill_ready", fill_ready, 1);

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fv, vecs[i].fd, vecs[i].fl, vecs[i].de);
            $display("vec %0d: fv=%0b fd=%0h de=%0b -> ready=%0b a_en=%b b_en=%b dv=%0b dd=%0h dl=%0b full=%b",
                     i, vecs[i].fv, vecs[i].fd, vecs[i].de, fill_ready, {en2a, en1a},
                     {en2b, en1b}, drain_valid, drain_data, drain_last, bank_full);
            chk("fill_ready", fill_ready, vecs[i].fr);
            chk("a_en", {en2a, en1a}, vecs[i].aen);
            chk("a_we", {we2a, we1a}, vecs[i].aen);
            if (vecs[i].aen == 2'b01) begin
                chk("addr1a", addr1a, vecs[i].aaddr);
                chk("w_data1a", w_data1a, vecs[i].fd);
            end
            if (vecs[i].aen == 2'b10) begin
                chk("addr2a", addr2a, vecs[i].aaddr);
                chk("w_data2a", w_data2a, vecs[i].fd);
            end
            chk("b_en", {en2b, en1b}, vecs[i].ben);
            if (vecs[i].ben == 2'b01) chk("addr1b", addr1b, vecs[i].baddr);
            if (vecs[i].ben == 2'b10) chk("addr2b", addr2b, vecs[i].baddr);
            chk("drain_valid", drain_valid, vecs[i].dv);
            if (vecs[i].dv) chk("drain_data", drain_data, vecs[i].dd);
            chk("drain_last", drain_last, vecs[i].dl);
            chk("bank_full", bank_full, vecs[i].bf);
            chk("busy", busy, (vecs[i].bf != 2'b00) || vecs[i].dv);
        end

        // ---------------- auto-close and both banks full ----------------
        apply_reset();
        for (int i = 0; i < DP; i++) begin
            drive(1, DW'(16'h1000 + i), 0, 0);
            if (i == DP - 1) begin
                chk("autoclose1_en1a", en1a, 1);
                chk("autoclose1_addr1a", addr1a, DP - 1);
            end
        end
        drive(0, 0, 0, 0);
        chk("autoclose1_bank_full", bank_full, 2'b01);
        chk("autoclose1_fill_ready", fill_ready, 1);
        for (int i = 0; i < DP; i++) begin
            drive(1, DW'(16'h2000 + i), 0, 0);
            if (i == DP - 1) begin
                chk("autoclose2_en2a", en2a, 1);
                chk("autoclose2_addr2a", addr2a, DP - 1);
            end
        end
        drive(1, 16'h3000, 0, 0);
        chk("both_full_bank_full", bank_full, 2'b11);
        chk("both_full_fill_ready", fill_ready, 0);
        chk("both_full_no_write", {en2a, en1a}, 2'b00);
        // Drain all 32 words of bank1 while a fill word waits.
        for (int i = 0; i < DP; i++) begin
            drive(1, 16'h3000, 0, 1);
            if (i > 0) begin
                chk("full_drain_valid", drain_valid, 1);
                chk("full_drain_data", drain_data, 16'h1000 + i - 1);
            end
            if (i == DP - 1) chk("last_issue_fill_ready", fill_ready, 0);
        end
        drive(1, 16'h3000, 0, 0);
        $display("full drain tail: dd=%0h dl=%0b ready=%0b en1a=%0b addr1a=%0d",
                 drain_data, drain_last, fill_ready, en1a, addr1a);
        chk("full_drain_data_last", drain_data, 16'h101F);
        chk("full_drain_last", drain_last, 1);
        chk("freed_fill_ready", fill_ready, 1);
        chk("freed_en1a", en1a, 1);
        chk("freed_addr1a", addr1a, 0);
        chk("freed_bank_full", bank_full, 2'b10);

        // ---------------- concurrent streaming over 4 tiles ----------------
        apply_reset();
        lens[0] = 5; lens[1] = 8; lens[2] = 3; lens[3] = 6;
        total = 0;
        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < lens[t]; w++) begin
                src_data[total] = DW'(16'h4000 + total);
                src_last[total] = (w == lens[t] - 1);
                total++;
            end
        end
        sent = 0;
        rcv  = 0;
        n    = 0;
        while (rcv < total && n < 300) begin
            if (sent < total) drive(1, src_data[sent], src_last[sent], 1);
            else              drive(0, 0, 0, 1);
            if (drain_valid) begin
                $display("stream word %0d: dd=%0h dl=%0b", rcv, drain_data, drain_last);
                chk("stream_data", drain_data, src_data[rcv]);
                chk("stream_last", drain_last, src_last[rcv]);
                rcv++;
            end
            if (fill_valid && fill_ready) sent++;
            n++;
        end
        chk("stream_count", rcv, total);
        drive(0, 0, 0, 1);
        chk("stream_no_extra", drain_valid, 0);
        chk("stream_bank_full", bank_full, 2'b00);

        // ---------------- reset mid-fill ----------------
        apply_reset();
        drive(1, 16'h5000, 0, 0);
        drive(1, 16'h5001, 1, 0);
        for (int i = 0; i < 7; i++) drive(1, DW'(16'h5100 + i), 0, 0);
        drive(0, 0, 0, 1);
        chk("pre_rst_bank_full", bank_full, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bank_full", bank_full, 2'b00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drain_valid", drain_valid, 0);
        chk("mid_rst_enables", {en1a, en2a, en1b, en2b}, 4'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 16'h6000, 0, 0);
        $display("after rst: en1a=%0b addr1a=%0d en2a=%0b", en1a, addr1a, en2a);
        chk("after_rst_en1a", en1a, 1);
        chk("after_rst_addr1a", addr1a, 0);

        // ---------------- clear mid-drain ----------------
        drive(1, 16'h6001, 0, 0);
        drive(1, 16'h6002, 1, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("pre_clr_data", drain_data, 16'h6000);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_cycle_data", drain_data, 16'h6001);
        drive(0, 0, 0, 0);
        clr = 1'b0;
        chk("after_clr_drain_valid", drain_valid, 0);
        chk("after_clr_bank_full", bank_full, 2'b00);
        chk("after_clr_busy", busy, 0);
        drive(1, 16'h7000, 0, 0);
        $display("after clr: en1a=%0b addr1a=%0d en2a=%0b", en1a, addr1a, en2a);
        chk("after_clr_en1a", en1a, 1);
        chk("after_clr_addr1a", addr1a, 0);
        drive(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gbf_db_ctrl.md
GBF_DB_CTRL -- requirements
Module: gbf_db_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 512, width of one buffer word.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 5, bank address width.
REQ-003 SHALL have parameter DEPTH, default 32, words per bank (DEPTH <= 2^ADDR_BITWIDTH).
REQ-004 SHALL have ports: clk input 1, the single clock; rst input 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports: clr input 1, synchronous soft clear; fill_valid input 1, fill word present; fill_data input DATA_BITWIDTH, fill word; fill_last input 1, last word of tile; fill_ready output 1, fill word accepted this cycle when high with fill_valid.
REQ-006 SHALL have ports: drain_en input 1, consumer requests a read this cycle; drain_valid output 1, drain_data valid; drain_data output DATA_BITWIDTH, read word; drain_last output 1, last word of tile.
REQ-007 SHALL have RAM-side ports: en1a, we1a, en2a, we2a output 1; addr1a, addr2a output ADDR_BITWIDTH; w_data1a, w_data2a output DATA_BITWIDTH; en1b, en2b output 1; addr1b, addr2b output ADDR_BITWIDTH; r_data1b, r_data2b input DATA_BITWIDTH (1-cycle registered read).
REQ-008 SHALL have status ports: bank_full output 2 (bit0 = bank1, bit1 = bank2); busy output 1, high when any bank is full or drain_valid is high.

Function
REQ-009 SHALL keep registers: wr_sel (bank under fill), rd_sel (bank under drain), wr_addr, rd_addr, full[1:0], len1/len2 (ADDR_BITWIDTH+1 bits, word count per bank).
REQ-010 SHALL drive fill_ready = !full[wr_sel] combinationally.
REQ-011 A fill beat (fill_valid && fill_ready) SHALL assert en/we of bank wr_sel with addr = wr_addr and w_data = fill_data in the same cycle; the other bank's a-port SHALL have en = we = 0.
REQ-012 On a fill beat with fill_last = 1 or wr_addr = DEPTH-1, the controller SHALL set full[wr_sel], store len = wr_addr+1, toggle wr_sel, and clear wr_addr; otherwise it SHALL increment wr_addr.
REQ-013 A read issue (drain_en && full[rd_sel]) SHALL assert en of bank rd_sel b-port with addr = rd_addr; the other b-port SHALL have en = 0.
REQ-014 On a read issue with rd_addr = len[rd_sel]-1, the controller SHALL clear full[rd_sel], toggle rd_sel, and clear rd_addr; otherwise it SHALL increment rd_addr.
REQ-015 drain_valid SHALL be high exactly one cycle after each read issue; drain_data SHALL equal r_data of the bank read in the issuing cycle; drain_last SHALL be high with drain_valid for the final word of a tile.
REQ-016 drain_en while full[rd_sel] = 0 SHALL issue no read and produce no drain_valid (no error, no state change).
REQ-017 Simultaneous fill beat and read issue SHALL both proceed (different banks by construction); setting full on one bank and clearing full on the other in the same cycle SHALL both take effect.
REQ-018 A bank freed by its last read issue SHALL accept fill writes from the next cycle; its final read data SHALL be unaffected.
REQ-019 With both banks full, fill_ready SHALL be 0 until a tile drain completes.
REQ-020 clr SHALL, on the next edge, return all registers to reset values, dominating fill and drain activity in that cycle.

Reset
REQ-021 While rst is high, all outputs SHALL be 0: fill_ready = 1 after release only (0 during rst is not required; fill_ready = !full[wr_sel] = 1), drain_valid = 0, drain_last = 0, bank_full = 00, busy = 0, all RAM enables 0.
REQ-022 Reset SHALL set wr_sel = rd_sel = bank1, wr_addr = rd_addr = 0, full = 00, len1 = len2 = 0; a reset mid-tile SHALL discard partial fills and pending reads.

Verification
REQ-023 Fill 4 words (A0..A3, fill_last on A3) -> we1a at addr 0..3, bank_full = 01, wr_sel = bank2; drain_en held 4 cycles -> drain_data A0..A3 each one cycle after issue, drain_last on A3, bank_full = 00.
REQ-024 Fill 32 words without fill_last -> auto-close at addr 31, len1 = 32; fill 32 more -> bank_full = 11, fill_ready = 0.
REQ-025 Both full, drain bank1 continuously -> fill_ready rises the cycle after last read issue; next fill writes bank1 addr 0.
REQ-026 Concurrent streaming: fill bank2 while draining bank1, one beat per cycle each -> no lost or duplicated words, ping-pong order preserved across 4 tiles.
REQ-027 drain_en asserted with bank_full = 00 -> no en1b/en2b, drain_valid stays 0.
REQ-028 rst asserted mid-fill (wr_addr = 7) and clr asserted mid-drain -> all state to reset values, bank_full = 00, next fill starts at bank1 addr 0.
